uart_tx_buffered: RTL and testbench

- Buffered UART transmitter: byte FIFO in front of a serialiser with programmable baud divider, 5–8 data bits, optional even parity and 1/2 stop bits.
- Sits in the SoC peripheral space as the send path of the board UARTs.
- Bench counterpart: the existing uart_rx checker, which decodes tx_o, so the configuration encoding matches uart_rx exactly.

---
 rtl/uart_tx_buffered.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : Buffered UART transmitter. A byte FIFO feeds a serialiser
//                with a programmable baud divider, 5..8 data bits, optional
//                even parity and one or two stop bits.
//                Optional macro UART_TX_CTS_EN adds an active-low
//                clear-to-send input (cts_ni) that gates the start of frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
   input  logic               clk_i,
   input  logic               rstn_i,
`ifdef UART_TX_CTS_EN
   input  logic               cts_ni,
`endif
   output logic               tx_o,
   output logic               busy_o,
   input  logic [15:0]        cfg_div_i,
   input  logic               cfg_en_i,
   input  logic               cfg_parity_en_i,
   input  logic [1:0]         cfg_bits_i,
   input  logic               cfg_stop_bits_i,
   input  logic [7:0]         tx_data_i,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   output logic [FIFO_AW:0]   fifo_level_o,
   output logic               tx_done_o
);

   localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   // ---------------- FIFO ----------------
   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   level_q, level_d;
   logic               push, pop;

   // ---------------- serialiser ----------------
   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d, div_q, div_d, div_eff;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [1:0]  bits_q, bits_d;
   logic        par_en_q, par_en_d, stop2_q, stop2_d, stopcnt_q, stopcnt_d;
   logic        par_q, par_d, tx_q, tx_d, done_pre_q, done_pre_d, done_q;
   logic        bit_end, can_start, load, cts_ok;

`ifdef UART_TX_CTS_EN
   logic cts_meta_q, cts_sync_q;

   // Two-flop synchroniser for the asynchronous clear-to-send input
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cts_meta_q <= 1'b1;
         cts_sync_q <= 1'b1;
      end else begin
         cts_meta_q <= cts_ni;
         cts_sync_q <= cts_meta_q;
      end
   end
   assign cts_ok = ~cts_sync_q;
`else
   assign cts_ok = 1'b1;
`endif

   assign push         = tx_valid_i && tx_ready_o;
   assign tx_ready_o   = (level_q != LVL_FULL);
   assign fifo_level_o = level_q;
   assign div_eff      = (cfg_div_i == 16'd0) ? 16'd1 : cfg_div_i;
   assign bit_end      = (cnt_q == div_q - 16'd1);
   assign can_start    = cfg_en_i && (level_q != '0) && cts_ok;

   // FIFO storage; contents need no reset since the level qualifies them
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= tx_data_i;
   end

   // Occupancy: simultaneous push and pop leaves the level unchanged
   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (!push && pop) level_d = level_q - LVL_ONE;
   end

   // FIFO pointers and level
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         level_q <= level_d;
      end
   end

   // Frame sequencing; tx_d is the line level for the bit the FSM is in,
   // so the line trails the state register by one clock throughout
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 16'd1;
      div_d      = div_q;
      shift_d    = shift_q;
      bitcnt_d   = bitcnt_q;
      bits_d     = bits_q;
      par_en_d   = par_en_q;
      stop2_d    = stop2_q;
      stopcnt_d  = stopcnt_q;
      par_d      = par_q;
      tx_d       = 1'b1;
      done_pre_d = 1'b0;
      load       = 1'b0;
      pop        = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            if (can_start) load = 1'b1;
         end
         S_START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               cnt_d    = 16'd0;
               bitcnt_d = 3'd0;
               state_d  = S_DATA;
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (bit_end) begin
               cnt_d    = 16'd0;
               shift_d  = shift_q >> 1;
               par_d    = par_q ^ shift_q[0];
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == {1'b1, bits_q}) begin
                  stopcnt_d = 1'b0;
                  state_d   = par_en_q ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            tx_d = par_q;
            if (bit_end) begin
               cnt_d     = 16'd0;
               stopcnt_d = 1'b0;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d = 16'd0;
               if (stopcnt_q == stop2_q) begin
                  done_pre_d = 1'b1;
                  state_d    = S_IDLE;
                  if (can_start) load = 1'b1;
               end else begin
                  stopcnt_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Pop the head byte and freeze the configuration for the new frame
      if (load) begin
         pop      = 1'b1;
         state_d  = S_START;
         cnt_d    = 16'd0;
         shift_d  = mem_q[rd_ptr_q];
         bits_d   = cfg_bits_i;
         par_en_d = cfg_parity_en_i;
         stop2_d  = cfg_stop_bits_i;
         div_d    = div_eff;
         par_d    = 1'b0;
      end
      // Disable mid-frame drops the current byte and idles the line
      if (!cfg_en_i && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         tx_d       = 1'b1;
         done_pre_d = 1'b0;
         cnt_d      = 16'd0;
      end
   end

   // Serialiser state and output registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         div_q      <= 16'd1;
         shift_q    <= 8'd0;
         bitcnt_q   <= 3'd0;
         bits_q     <= 2'd0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
         stopcnt_q  <= 1'b0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         done_pre_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         shift_q    <= shift_d;
         bitcnt_q   <= bitcnt_d;
         bits_q     <= bits_d;
         par_en_q   <= par_en_d;
         stop2_q    <= stop2_d;
         stopcnt_q  <= stopcnt_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         done_pre_q <= done_pre_d;
         done_q     <= done_pre_q;
      end
   end

   assign tx_o      = tx_q;
   assign tx_done_o = done_q;
   // done_pre_q covers the final stop-bit clock still on the line
   assign busy_o    = (state_q != S_IDLE) || (level_q != '0) || done_pre_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`timescale 1ns/1ps
module tb_uart_tx_buffered;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        tx_o, busy_o, tx_ready_o, tx_done_o;
   logic [15:0] cfg_div_i = 16'd1;
   logic        cfg_en_i = 1'b0, cfg_parity_en_i = 1'b0, cfg_stop_bits_i = 1'b0;
   logic [1:0]  cfg_bits_i = 2'b11;
   logic [7:0]  tx_data_i = 8'h00;
   logic        tx_valid_i = 1'b0;
   logic [4:0]  fifo_level_o;
`ifdef UART_TX_CTS_EN
   logic        cts_ni = 1'b0;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];

   uart_tx_buffered #(.FIFO_DEPTH(16)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
`ifdef UART_TX_CTS_EN
      .cts_ni(cts_ni),
`endif
      .tx_o(tx_o), .busy_o(busy_o), .cfg_div_i(cfg_div_i), .cfg_en_i(cfg_en_i),
      .cfg_parity_en_i(cfg_parity_en_i), .cfg_bits_i(cfg_bits_i),
      .cfg_stop_bits_i(cfg_stop_bits_i), .tx_data_i(tx_data_i),
      .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .fifo_level_o(fifo_level_o), .tx_done_o(tx_done_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic write_byte(input logic [7:0] b, input bit accept);
      @(negedge clk_i);
      tx_valid_i = 1'b1;
      tx_data_i  = b;
      @(posedge clk_i);
      #1;
      tx_valid_i = 1'b0;
      if (accept) exp_q.push_back(b);
   endtask

   // Line decoder: waits for a start bit, samples each bit mid-period
   task automatic rx_frame(input int div, input int nb, input bit par_en, input int stops,
                           output logic [7:0] d, output logic p, output logic stop_ok,
                           output int t0, output bit to);
      int w;
      d = 8'h00; p = 1'b0; stop_ok = 1'b1; t0 = 0; to = 1'b0; w = 0;
      while (tx_o !== 1'b0 && w < 20000) begin
         @(negedge clk_i);
         w++;
      end
      if (tx_o !== 1'b0) begin
         to = 1'b1;
         return;
      end
      t0 = cyc;
      repeat (div / 2) @(negedge clk_i);
      for (int i = 0; i < nb; i++) begin
         repeat (div) @(negedge clk_i);
         d[i] = tx_o;
      end
      if (par_en) begin
         repeat (div) @(negedge clk_i);
         p = tx_o;
      end
      for (int s = 0; s < stops; s++) begin
         repeat (div) @(negedge clk_i);
         if (tx_o !== 1'b1) stop_ok = 1'b0;
      end
   endtask

   task automatic wait_done(output int t, output bit to);
      int w;
      w = 0; to = 1'b0;
      while (tx_done_o !== 1'b1 && w < 20000) begin
         @(negedge clk_i);
         w++;
      end
      if (tx_done_o !== 1'b1) to = 1'b1;
      t = cyc;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk_i);
      n_cmp++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
      n_cmp++; if (tx_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", tx_ready_o); end
      n_cmp++; if (fifo_level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level_o); end
      n_cmp++; if (tx_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", tx_done_o); end
      rstn_i = 1'b1;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_8n1;
      logic [7:0] d, e; logic p, sok; int t0, t; bit to;
      cfg_div_i = 16'd104; cfg_bits_i = 2'b11; cfg_parity_en_i = 1'b0;
      cfg_stop_bits_i = 1'b0; cfg_en_i = 1'b1;
      write_byte(8'h55, 1'b1);
      @(negedge clk_i);
      n_cmp++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL lat_n1 got %b want 1", tx_o); end
      @(negedge clk_i);
      n_cmp++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL lat_n2 got %b want 1", tx_o); end
      n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_8n1 got %b want 1", busy_o); end
      @(negedge clk_i);
      n_cmp++; if (tx_o !== 1'b0) begin n_fail++; $display("FAIL lat_start got %b want 0", tx_o); end
      rx_frame(104, 8, 1'b0, 1, d, p, sok, t0, to);
      e = exp_q.pop_front();
      n_cmp++; if (to || d !== e) begin n_fail++; $display("FAIL data_8n1 got %h want %h", d, e); end
      n_cmp++; if (sok !== 1'b1) begin n_fail++; $display("FAIL stop_8n1 got %b want 1", sok); end
      wait_done(t, to);
      n_cmp++; if (to || (t - t0) != 1040) begin n_fail++; $display("FAIL done_time_8n1 got %0d want 1040", t - t0); end
      @(negedge clk_i);
      n_cmp++; if (tx_done_o !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", tx_done_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_end got %b want 0", busy_o); end
   endtask

   task automatic test_burst;
      logic [7:0] d, e; logic p, sok; int t0, tprev, t; bit to;
      cfg_en_i = 1'b0; cfg_div_i = 16'd4;
      for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
      @(negedge clk_i);
      n_cmp++; if (fifo_level_o !== 5'd16) begin n_fail++; $display("FAIL burst_level got %0d want 16", fifo_level_o); end
      n_cmp++; if (tx_ready_o !== 1'b0) begin n_fail++; $display("FAIL burst_ready got %b want 0", tx_ready_o); end
      write_byte(8'hAA, 1'b0);
      @(negedge clk_i);
      n_cmp++; if (fifo_level_o !== 5'd16) begin n_fail++; $display("FAIL full_drop got %0d want 16", fifo_level_o); end
      cfg_en_i = 1'b1;
      tprev = 0;
      for (int k = 0; k < 16; k++) begin
         rx_frame(4, 8, 1'b0, 1, d, p, sok, t0, to);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
         n_cmp++; if (to || d !== e || sok !== 1'b1) begin n_fail++; $display("FAIL burst_data[%0d] got %h want %h", k, d, e); end
         if (k > 0) begin
            n_cmp++; if ((t0 - tprev) != 40) begin n_fail++; $display("FAIL burst_gap[%0d] got %0d want 40", k, t0 - tprev); end
         end
         tprev = t0;
      end
      n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL burst_busy_last got %b want 1", busy_o); end
      wait_done(t, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL burst_done got timeout want pulse"); end
      @(negedge clk_i);
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL burst_busy_fall got %b want 0", busy_o); end
   endtask

   task automatic test_formats;
      logic [7:0] d, e; logic p, sok; int t0, t; bit to;
      // 7E1
      cfg_div_i = 16'd6; cfg_bits_i = 2'b10; cfg_parity_en_i = 1'b1; cfg_stop_bits_i = 1'b0;
      write_byte(8'h41, 1'b1);
      rx_frame(6, 7, 1'b1, 1, d, p, sok, t0, to);
      e = exp_q.pop_front() & 8'h7F;
      n_cmp++; if (to || d !== e) begin n_fail++; $display("FAIL data_7e1 got %h want %h", d, e); end
      n_cmp++; if (p !== ^e) begin n_fail++; $display("FAIL parity_7e1 got %b want %b", p, ^e); end
      wait_done(t, to);
      n_cmp++; if (to || (t - t0) != 60) begin n_fail++; $display("FAIL len_7e1 got %0d want 60", t - t0); end
      // 5 data bits, 2 stop bits
      cfg_bits_i = 2'b00; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b1;
      write_byte(8'hFF, 1'b1);
      rx_frame(6, 5, 1'b0, 2, d, p, sok, t0, to);
      e = exp_q.pop_front() & 8'h1F;
      n_cmp++; if (to || d !== e || sok !== 1'b1) begin n_fail++; $display("FAIL data_5n2 got %h want %h", d, e); end
      wait_done(t, to);
      n_cmp++; if (to || (t - t0) != 48) begin n_fail++; $display("FAIL len_5n2 got %0d want 48", t - t0); end
      // divider 0 behaves as 1
      cfg_div_i = 16'd0; cfg_bits_i = 2'b11; cfg_stop_bits_i = 1'b0;
      write_byte(8'hC3, 1'b1);
      rx_frame(1, 8, 1'b0, 1, d, p, sok, t0, to);
      e = exp_q.pop_front();
      n_cmp++; if (to || d !== e) begin n_fail++; $display("FAIL data_div0 got %h want %h", d, e); end
      wait_done(t, to);
      n_cmp++; if (to || (t - t0) != 10) begin n_fail++; $display("FAIL len_div0 got %0d want 10", t - t0); end
      repeat (3) @(negedge clk_i);
   endtask

   task automatic test_simul;
      logic [7:0] d, e; logic p, sok; int t0; bit to;
      cfg_en_i = 1'b0; cfg_div_i = 16'd4;
      write_byte(8'hA5, 1'b1);
      @(negedge clk_i);
      cfg_en_i = 1'b1; tx_valid_i = 1'b1; tx_data_i = 8'h5A;
      @(posedge clk_i);
      #1;
      tx_valid_i = 1'b0;
      exp_q.push_back(8'h5A);
      n_cmp++; if (fifo_level_o !== 5'd1) begin n_fail++; $display("FAIL simul_level got %0d want 1", fifo_level_o); end
      for (int k = 0; k < 2; k++) begin
         rx_frame(4, 8, 1'b0, 1, d, p, sok, t0, to);
         e = exp_q.pop_front();
         n_cmp++; if (to || d !== e) begin n_fail++; $display("FAIL simul_data[%0d] got %h want %h", k, d, e); end
      end
      repeat (6) @(negedge clk_i);
   endtask

   task automatic test_abort;
      logic [7:0] d, e; logic p, sok; int t0, w, ndone; bit to, hi;
      cfg_en_i = 1'b0; cfg_div_i = 16'd8;
      write_byte(8'h3C, 1'b1);
      write_byte(8'h81, 1'b1);
      write_byte(8'h7E, 1'b1);
      @(negedge clk_i);
      cfg_en_i = 1'b1;
      w = 0;
      while (tx_o !== 1'b0 && w < 100) begin @(negedge clk_i); w++; end
      repeat (10) @(negedge clk_i);
      n_cmp++; if (tx_o !== 1'b0) begin n_fail++; $display("FAIL abort_pre got %b want 0", tx_o); end
      cfg_en_i = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL abort_tx got %b want 1", tx_o); end
      ndone = 0; hi = 1'b1;
      repeat (40) begin
         @(negedge clk_i);
         if (tx_done_o === 1'b1) ndone++;
         if (tx_o !== 1'b1) hi = 1'b0;
      end
      n_cmp++; if (ndone != 0 || hi !== 1'b1) begin n_fail++; $display("FAIL abort_done got %0d pulses want 0", ndone); end
      n_cmp++; if (fifo_level_o !== 5'd2) begin n_fail++; $display("FAIL abort_level got %0d want 2", fifo_level_o); end
      void'(exp_q.pop_front());
      cfg_en_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rx_frame(8, 8, 1'b0, 1, d, p, sok, t0, to);
         e = exp_q.pop_front();
         n_cmp++; if (to || d !== e) begin n_fail++; $display("FAIL abort_resume[%0d] got %h want %h", k, d, e); end
      end
      repeat (8) @(negedge clk_i);
      // asynchronous reset in the middle of a frame
      write_byte(8'h99, 1'b0);
      write_byte(8'h98, 1'b0);
      w = 0;
      while (tx_o !== 1'b0 && w < 100) begin @(negedge clk_i); w++; end
      repeat (5) @(negedge clk_i);
      #2 rstn_i = 1'b0;
      #1;
      n_cmp++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx got %b want 1", tx_o); end
      n_cmp++; if (fifo_level_o !== 5'd0) begin n_fail++; $display("FAIL rst_mid_level got %0d want 0", fifo_level_o); end
      @(negedge clk_i);
      rstn_i = 1'b1;
      repeat (2) @(negedge clk_i);
   endtask

`ifdef UART_TX_CTS_EN
   task automatic test_cts;
      logic [7:0] d, e; logic p, sok; int t0, w; bit to, hi;
      cfg_en_i = 1'b1; cfg_div_i = 16'd4; cfg_bits_i = 2'b11; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
      cts_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      write_byte(8'h12, 1'b1);
      hi = 1'b1;
      repeat (20) begin @(negedge clk_i); if (tx_o !== 1'b1) hi = 1'b0; end
      n_cmp++; if (hi !== 1'b1) begin n_fail++; $display("FAIL cts_hold got low want high"); end
      cts_ni = 1'b0;
      w = 0;
      while (tx_o !== 1'b0 && w < 4) begin @(negedge clk_i); w++; end
      n_cmp++; if (tx_o !== 1'b0) begin n_fail++; $display("FAIL cts_start got %b want 0", tx_o); end
      fork
         rx_frame(4, 8, 1'b0, 1, d, p, sok, t0, to);
         begin
            repeat (5) @(negedge clk_i);
            cts_ni = 1'b1;
            write_byte(8'h34, 1'b1);
         end
      join
      e = exp_q.pop_front();
      n_cmp++; if (to || d !== e || sok !== 1'b1) begin n_fail++; $display("FAIL cts_frame got %h want %h", d, e); end
      hi = 1'b1;
      repeat (30) begin @(negedge clk_i); if (tx_o !== 1'b1) hi = 1'b0; end
      n_cmp++; if (hi !== 1'b1 || fifo_level_o !== 5'd1) begin n_fail++; $display("FAIL cts_wait got level %0d want 1", fifo_level_o); end
      cts_ni = 1'b0;
      rx_frame(4, 8, 1'b0, 1, d, p, sok, t0, to);
      e = exp_q.pop_front();
      n_cmp++; if (to || d !== e) begin n_fail++; $display("FAIL cts_next got %h want %h", d, e); end
      repeat (6) @(negedge clk_i);
   endtask
`endif

   initial begin
      test_reset();
      test_8n1();
      test_burst();
      test_formats();
      test_simul();
      test_abort();
`ifdef UART_TX_CTS_EN
      test_cts();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
